// File: rtl/scs_pkg.sv
// scs_pkg: FSM state encoding and default parameter constants shared by the scs_engine slice
package scs_pkg;
    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, CHECK, DONE} state_t;
    localparam int RAM_WIDTH_DEF     = 8;
    localparam int RAM_ADDR_BITS_DEF = 10;
    localparam int SUM_BYTES_DEF     = 2;
    localparam int WEIGHT_STEPS_DEF  = 4;
endpackage

// File: rtl/scs_accum.sv
// scs_accum: weighted accumulator, sum += word << step (mod 2^SUM_W); ports: clock, reset (async low), clear, enable, word, step -> sum
module scs_accum #(
    parameter int RAM_WIDTH = 8,
    parameter int SUM_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [RAM_WIDTH-1:0] word,
    input  logic [2:0]           step,
    output logic [SUM_W-1:0]     sum
);
    always_ff @(posedge clock or negedge reset)
        if (!reset) sum <= '0;
        else if (clear) sum <= '0;
        else if (enable) sum <= sum + (SUM_W'(word) << step);
endmodule

// File: rtl/scs_engine.sv
// scs_engine: weighted memory checksum generate/check engine; ports: clock, reset (async low), start/mode/base_addr/length request, busy/done/match/error/checksum status, write_enable/address/mem_input/mem_output memory port
import scs_pkg::*;
module scs_engine #(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter int SUM_BYTES     = SUM_BYTES_DEF,
    parameter int WEIGHT_STEPS  = WEIGHT_STEPS_DEF,
    parameter int SUM_W         = SUM_BYTES * RAM_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS-1:0] length,
    output logic                     busy,
    output logic                     done,
    output logic                     match,
    output logic                     error,
    output logic [SUM_W-1:0]         checksum,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     mem_output,
    output logic [RAM_WIDTH-1:0]     mem_input
);
    localparam int AB = RAM_ADDR_BITS;
    state_t state, next;
    logic [AB-1:0] base_q, len_q, idx, idx_m1;
    logic mode_q, rd_v, accept, range_bad;
    logic [2:0] step_q, rd_step;
    logic [AB+1:0] end_addr;
    logic [SUM_W-1:0] sum;
    logic [RAM_WIDTH-1:0] wr_byte, chk_byte;
    assign accept    = state == IDLE && start;
    assign end_addr  = (AB+2)'(base_addr) + (AB+2)'(length) + (AB+2)'(SUM_BYTES);
    assign range_bad = end_addr > {2'b01, {AB{1'b0}}};
    assign idx_m1    = idx - 1'b1;
    assign wr_byte   = RAM_WIDTH'(sum >> (32'(idx) * RAM_WIDTH));
    assign chk_byte  = RAM_WIDTH'(sum >> (32'(idx_m1) * RAM_WIDTH));
    // range errors and empty payloads both pass through DRAIN so no READ address is ever issued
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = (range_bad || length == '0) ? DRAIN : READ;
            READ:    if (idx == len_q - 1'b1) next = DRAIN;
            DRAIN:   next = error ? DONE : mode_q ? CHECK : WRITE;
            WRITE:   if (idx == AB'(SUM_BYTES - 1)) next = DONE;
            CHECK:   if (idx == AB'(SUM_BYTES)) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            idx     <= '0;
            step_q  <= '0;
            rd_v    <= 1'b0;
            rd_step <= '0;
            match   <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= next;
            rd_v    <= state == READ;
            rd_step <= step_q;
            if (accept) begin
                base_q <= base_addr;
                len_q  <= length;
                mode_q <= mode;
                error  <= range_bad;
                match  <= 1'b0;
                idx    <= '0;
                step_q <= '0;
            end else if (state == READ) begin
                idx    <= next == READ ? idx + 1'b1 : '0;
                step_q <= step_q == 3'(WEIGHT_STEPS - 1) ? '0 : step_q + 1'b1;
            end else if (state == WRITE || state == CHECK) idx <= idx + 1'b1;
            if (state == DRAIN) match <= mode_q && !error;
            // read data lags the address by one cycle, so CHECK compares byte idx-1
            if (state == CHECK && idx != '0 && mem_output != chk_byte) match <= 1'b0;
        end
    scs_accum #(.RAM_WIDTH(RAM_WIDTH), .SUM_W(SUM_W)) u_accum (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (rd_v),
        .word   (mem_output),
        .step   (rd_step),
        .sum    (sum)
    );
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign write_enable = state == WRITE;
    assign checksum     = sum;
    assign mem_input    = write_enable ? wr_byte : '0;
    assign address      = state == READ ? base_q + idx :
                          (write_enable || (state == CHECK && idx < AB'(SUM_BYTES))) ? base_q + len_q + idx : '0;
endmodule

// File: tb/tb_scs_engine.sv
// tb_scs_engine: directed self-checking bench for scs_engine with a one-cycle-latency memory model
module tb_scs_engine;
    logic clock = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
    logic [9:0] base_addr = '0, length = '0, address;
    logic busy, done, match, error, write_enable;
    logic [15:0] checksum;
    logic [7:0] mem_output, mem_input;
    logic [7:0] mem [1024];
    int we_cnt = 0, n_cmp = 0, n_bad = 0, lat, we0;

    scs_engine dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .match(match), .error(error), .checksum(checksum),
        .write_enable(write_enable), .address(address),
        .mem_output(mem_output), .mem_input(mem_input)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (write_enable) begin
            mem[address] <= mem_input;
            we_cnt <= we_cnt + 1;
        end
        mem_output <= mem[address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [9:0] b, input logic [9:0] l, input logic m, output int lt);
        @(negedge clock);
        base_addr = b; length = l; mode = m; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lt = 1;
        while (!done && lt < 2000) begin
            @(negedge clock);
            lt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clock);
        chk("reset_flags", {busy, done, match, error, write_enable}, 0);
        chk("reset_sum", checksum, 0);
        chk("reset_addr", address, 0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
        mem[5] = 8'hAA; mem[6] = 8'hAA;
        we0 = we_cnt;
        run(10'd0, 10'd5, 1'b0, lat);
        chk("gen_latency", lat, 9);
        chk("gen_checksum", checksum, 16'h0036);
        chk("gen_error", error, 0);
        chk("gen_match", match, 0);
        @(negedge clock);
        chk("gen_mem5", mem[5], 8'h36);
        chk("gen_mem6", mem[6], 8'h00);
        chk("gen_writes", we_cnt - we0, 2);

        we0 = we_cnt;
        run(10'd0, 10'd5, 1'b1, lat);
        chk("chk_latency", lat, 10);
        chk("chk_match", match, 1);
        chk("chk_checksum", checksum, 16'h0036);
        mem[5] = 8'h37;
        run(10'd0, 10'd5, 1'b1, lat);
        chk("chk_mismatch", match, 0);
        chk("chk_no_writes", we_cnt - we0, 0);

        for (int i = 0; i < 300; i++) mem[i] = 8'hFF;
        run(10'd0, 10'd300, 1'b0, lat);
        chk("wrap_latency", lat, 304);
        chk("wrap_checksum", checksum, 16'h609B);
        @(negedge clock);
        chk("wrap_mem_lo", mem[300], 8'h9B);
        chk("wrap_mem_hi", mem[301], 8'h60);

        for (int i = 1018; i < 1022; i++) mem[i] = 8'h01;
        run(10'd1018, 10'd4, 1'b0, lat);
        chk("edge_error", error, 0);
        chk("edge_checksum", checksum, 16'h000F);
        @(negedge clock);
        chk("edge_mem_top", {mem[1023], mem[1022]}, 16'h000F);

        we0 = we_cnt;
        run(10'd1020, 10'd4, 1'b0, lat);
        chk("range_latency", lat, 2);
        chk("range_error", error, 1);
        chk("range_checksum", checksum, 0);
        run(10'd1020, 10'd4, 1'b1, lat);
        chk("range_chk_match", match, 0);
        chk("range_chk_error", error, 1);
        chk("range_no_writes", we_cnt - we0, 0);

        for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
        mem[5] = 8'hEE; mem[6] = 8'hEE;
        we0 = we_cnt;
        @(negedge clock);
        base_addr = 10'd0; length = 10'd5; mode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("abort_busy", busy, 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_flags", {busy, done, match, error, write_enable}, 0);
        chk("abort_addr", address, 0);
        chk("abort_sum", checksum, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        chk("abort_no_write", we_cnt - we0, 0);
        chk("abort_mem5", mem[5], 8'hEE);
        chk("abort_idle", busy, 0);
        run(10'd0, 10'd5, 1'b0, lat);
        chk("rerun_latency", lat, 9);
        chk("rerun_checksum", checksum, 16'h0036);
        @(negedge clock);
        chk("rerun_mem", {mem[6], mem[5]}, 16'h0036);

        mem[10] = 8'h55; mem[11] = 8'h55;
        we0 = we_cnt;
        @(negedge clock);
        base_addr = 10'd10; length = 10'd0; mode = 1'b0; start = 1'b1;
        @(negedge clock);
        base_addr = 10'd100; length = 10'd5; mode = 1'b1;
        lat = 1;
        while (!done && lat < 2000) begin
            @(negedge clock);
            start = 1'b0;
            lat++;
        end
        start = 1'b0;
        chk("zero_latency", lat, 4);
        chk("zero_checksum", checksum, 0);
        chk("zero_error", error, 0);
        repeat (3) @(negedge clock);
        chk("zero_writes", we_cnt - we0, 2);
        chk("zero_mem", {mem[11], mem[10]}, 16'h0000);
        chk("busy_start_ignored", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scs_engine.md
SCS_ENGINE -- requirements
Module: scs_engine

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 8, meaning memory data width in bits.
REQ-002 The block SHALL have parameter RAM_ADDR_BITS, default 10, meaning memory address width.
REQ-003 The block SHALL have parameter SUM_BYTES, default 2, meaning checksum width in memory words; SUM_W = SUM_BYTES*RAM_WIDTH.
REQ-004 The block SHALL have parameter WEIGHT_STEPS, default 4, range 1..8, meaning the length of the weight cycle.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have these ports, one per line:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle request, sampled in IDLE only.
- mode  in  1  0 = generate and write back; 1 = check against stored value.
- base_addr  in  RAM_ADDR_BITS  first payload address, latched at start.
- length  in  RAM_ADDR_BITS  payload word count, latched at start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle completion pulse.
- match  out  1  check result, valid with done, held until next start.
- error  out  1  range error, valid with done, held until next start.
- checksum  out  SUM_W  final sum, valid with done, held until next start.
- write_enable  out  1  memory write strobe.
- address  out  RAM_ADDR_BITS  memory address.
- mem_output  in  RAM_WIDTH  read data, one cycle after address.
- mem_input  out  RAM_WIDTH  write data.

Function
REQ-007 States SHALL be IDLE, READ, DRAIN, WRITE, CHECK, DONE.
REQ-008 IDLE SHALL go to READ on start; start while busy SHALL be ignored.
REQ-009 READ SHALL present base_addr+i for i = 0..length-1, one address per cycle.
REQ-010 Each payload word i SHALL be accumulated as sum += word << (i mod WEIGHT_STEPS), modulo 2^SUM_W.
REQ-011 DRAIN SHALL last one cycle and capture the last read word.
REQ-012 With mode=0, WRITE SHALL drive write_enable for SUM_BYTES consecutive cycles, writing checksum little-endian at base_addr+length+k, k = 0..SUM_BYTES-1.
REQ-013 With mode=1, CHECK SHALL read SUM_BYTES words at the same addresses and compare them with the sum; match=1 only on full equality; write_enable SHALL stay 0.
REQ-014 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-015 Latency from accepted start to done SHALL be length+SUM_BYTES+2 cycles in mode 0 and length+SUM_BYTES+3 in mode 1.
REQ-016 length=0 SHALL skip READ, giving checksum 0, followed by normal write or check.
REQ-017 If base_addr+length+SUM_BYTES > 2^RAM_ADDR_BITS, the block SHALL go straight to DONE with error=1, make no memory access, and give match=0 and checksum=0.
REQ-018 write_enable SHALL be 0 in every state except WRITE.

Reset
REQ-019 Asserting reset SHALL, asynchronously and at any time including mid-operation, force state IDLE and set all outputs and the accumulator to 0.
REQ-020 An operation aborted by reset SHALL NOT resume; no write SHALL occur after reset asserts.

Structure
REQ-021 Package scs_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-022 Weighting and accumulation SHALL be in one sub-module, scs_accum (inputs: clear, enable, word, step index; output: sum).

Verification
REQ-023 Generate: base 0, length 5, data 01 02 03 04 05 -> checksum 0x0036; writes 0x36@5 and 0x00@6; done 9 cycles after start.
REQ-024 Check: the same memory with 36 00 at addresses 5..6 -> match=1; with 37 00 -> match=0; write_enable never asserted.
REQ-025 Wrap: length 300, all words 0xFF -> checksum 0x609B (286875 mod 65536).
REQ-026 Range: base 1020, length 4 -> error=1, done 2 cycles after start, no write_enable, checksum 0.
REQ-027 Reset abort: reset asserted on cycle 3 of READ -> all outputs 0 immediately; no write; a new start then completes normally.
REQ-028 Degenerate: length 0 at base 10, mode 0 -> writes 00@10 and 00@11; start asserted during busy is ignored.
